// File: rtl/regfile_pkg.sv
// Shared constants, state encoding and address-width helper for the
// multi-port integer register file.
package regfile_pkg;

    localparam int XLEN_DEF      = 32;
    localparam int REG_DEPTH_DEF = 32;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

    function automatic int rf_aw(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear-sweep sequencer: walks cnt from 1 to DEPTH-1 zeroing one register
// per cycle, started by srst or by a clr_req pulse while idle.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int DEPTH = REG_DEPTH_DEF,
    localparam int AW   = rf_aw(DEPTH)
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          clr_req,
    output logic          clr_en,
    output logic [AW-1:0] clr_addr,
    output rf_state_t     state
);

    localparam logic [AW-1:0] CNT_FIRST = AW'(1);
    localparam logic [AW-1:0] CNT_LAST  = AW'(DEPTH - 1);

    rf_state_t       r_state;
    rf_state_t       w_state_nxt;
    logic [AW-1:0]   r_cnt;
    logic [AW-1:0]   w_cnt_nxt;

    // clr_req is only honoured from IDLE; a sweep in flight is never extended.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            RF_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = RF_CLEAR;
                    w_cnt_nxt   = CNT_FIRST;
                end
            end
            RF_CLEAR: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = RF_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_FIRST;
                end
            end
            default: begin
                w_state_nxt = RF_CLEAR;
                w_cnt_nxt   = CNT_FIRST;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_state <= RF_CLEAR;
            r_cnt   <= CNT_FIRST;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Storage is left untouched while reset is held.
    assign clr_en   = (r_state == RF_CLEAR) && !srst;
    assign clr_addr = r_cnt;
    assign state    = r_state;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with hardwired-zero x0, optional
// write-to-read bypass and a sequenced clear sweep reported through busy.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int DEPTH  = REG_DEPTH_DEF,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1,
    localparam int AW    = rf_aw(DEPTH)
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    input  logic                   we,
    input  logic [AW-1:0]          wa,
    input  logic [XLEN-1:0]        wd,
    input  logic                   clr_req,
    output logic                   busy
);

    logic [XLEN-1:0] r_mem [DEPTH];

    logic            w_clr_en;
    logic [AW-1:0]   w_clr_addr;
    rf_state_t       w_state;
    logic            w_user_wr;
    logic            w_wr_en;
    logic [AW-1:0]   w_wr_addr;
    logic [XLEN-1:0] w_wr_data;

    regfile_clear_fsm #(
        .DEPTH (DEPTH)
    ) u_clear_fsm (
        .clk      (clk),
        .srst     (srst),
        .clr_req  (clr_req),
        .clr_en   (w_clr_en),
        .clr_addr (w_clr_addr),
        .state    (w_state)
    );

    assign busy = (w_state == RF_CLEAR);

    // Sweep and user writes are mutually exclusive because clr_en implies busy.
    assign w_user_wr = we && !busy && !srst && (wa != '0);
    assign w_wr_en   = w_clr_en || w_user_wr;
    assign w_wr_addr = w_clr_en ? w_clr_addr : wa;
    assign w_wr_data = w_clr_en ? '0 : wd;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic [XLEN-1:0] w_rd_val;

        assign w_ra = rd_addr[g*AW +: AW];

        always_comb begin
            w_rd_val = '0;
            if (busy || (w_ra == '0)) begin
                w_rd_val = '0;
            end else if ((BYPASS != 0) && we && (wa == w_ra)) begin
                w_rd_val = wd;
            end else begin
                w_rd_val = r_mem[w_ra];
            end
        end

        assign rd_data[g*XLEN +: XLEN] = w_rd_val;
    end

endmodule
